// File: rtl/common_pkg.sv
// Shared types and helpers for the stream multiplexer: lock-FSM states and
// a pointer-width helper that keeps a 1-bit pointer for single-channel builds.
package common_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant searched from ptr with wrap, or a forced
// grant to i_hold_idx while a packet holds the output. Owns the priority pointer.
module rr_arb
   import common_pkg::*;
#(
   parameter int  N  = 4,
   localparam int PW = ptr_w(N)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic [N-1:0]  i_req,
   input  logic          i_ack,
   input  logic          i_hold,
   input  logic [PW-1:0] i_hold_idx,
   output logic [N-1:0]  o_gnt
);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gnt_idx;
   logic [N-1:0]  rr_gnt;
   logic [N-1:0]  hold_gnt;
   logic          found;

   // First requester at or after ptr, wrapping modulo N.
   always_comb begin
      rr_gnt = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (!found && (k == (int'(ptr_q) + i) % N) && i_req[k]) begin
               rr_gnt[k] = 1'b1;
               found     = 1'b1;
            end
         end
      end
   end

   always_comb begin
      hold_gnt = '0;
      for (int k = 0; k < N; k++) begin
         hold_gnt[k] = (int'(i_hold_idx) == k);
      end
   end

   assign o_gnt = i_hold ? hold_gnt : rr_gnt;

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (o_gnt[k]) gnt_idx = PW'(k);
      end
      ptr_d = ptr_q;
      if (i_ack) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + PW'(1);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with round-robin arbitration, a
// registered output stage and optional packet lock (LOCK=1 holds grant until i_last).
module stream_mux_rr
   import common_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 32,
   parameter bit LOCK = 1'b0
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic [N-1:0]        i_valid,
   input  logic [N-1:0][W-1:0] i_data,
   input  logic [N-1:0]        i_last,
   output logic [N-1:0]        o_ready,
   output logic                o_valid,
   output logic [W-1:0]        o_data,
   output logic                o_last,
   output logic [N-1:0]        o_sel,
   input  logic                i_ready
);

   localparam int PW = ptr_w(N);

   lock_state_e   st_q, st_d;
   logic [PW-1:0] lk_q, lk_d;
   logic [PW-1:0] gnt_idx;
   logic [N-1:0]  gnt;
   logic          take, acc, sel_last;
   logic [W-1:0]  sel_data;
   logic          o_valid_q, o_valid_d;
   logic [W-1:0]  o_data_q, o_data_d;
   logic          o_last_q, o_last_d;
   logic [N-1:0]  o_sel_q, o_sel_d;

   assign take = !o_valid_q || i_ready;

   rr_arb #(.N(N)) u_arb (
      .clk        (clk),
      .arst_n     (arst_n),
      .i_req      (i_valid),
      .i_ack      (acc),
      .i_hold     (st_q == LOCKED),
      .i_hold_idx (lk_q),
      .o_gnt      (gnt)
   );

   // One-hot AND-OR select of the granted channel.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      gnt_idx  = '0;
      for (int k = 0; k < N; k++) begin
         sel_data = sel_data | ({W{gnt[k]}} & i_data[k]);
         sel_last = sel_last | (gnt[k] & i_last[k]);
         if (gnt[k]) gnt_idx = PW'(k);
      end
   end

   // Readies are held low while reset is asserted even though take=1 then.
   assign acc     = arst_n && take && |(gnt & i_valid);
   assign o_ready = (arst_n && take) ? gnt : '0;

   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_last_d  = o_last_q;
      o_sel_d   = o_sel_q;
      st_d      = st_q;
      lk_d      = lk_q;
      if (take) o_valid_d = acc;
      if (acc) begin
         o_data_d = sel_data;
         o_last_d = sel_last;
         o_sel_d  = gnt;
      end
      if (LOCK && acc) begin
         if (st_q == ARB && !sel_last) begin
            st_d = LOCKED;
            lk_d = gnt_idx;
         end else if (st_q == LOCKED && sel_last) begin
            st_d = ARB;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
         o_sel_q   <= '0;
         st_q      <= ARB;
         lk_q      <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_last_q  <= o_last_d;
         o_sel_q   <= o_sel_d;
         st_q      <= st_d;
         lk_q      <= lk_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_last  = o_last_q;
   assign o_sel   = o_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed-vector bench: one instance per arbitration mode on shared inputs,
// with hand-computed tables and reset sequences.
module tb_stream_mux_rr;

   localparam int N = 4;
   localparam int W = 32;

   logic                clk = 1'b0;
   logic                arst_n;
   logic [N-1:0]        i_valid, i_last;
   logic [N-1:0][W-1:0] i_data;
   logic                i_ready;
   logic [N-1:0]        o_ready0, o_sel0, o_ready1, o_sel1;
   logic                o_valid0, o_last0, o_valid1, o_last1;
   logic [W-1:0]        o_data0, o_data1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.N(N), .W(W), .LOCK(1'b0)) dut0 (
      .clk(clk), .arst_n(arst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
      .o_ready(o_ready0), .o_valid(o_valid0), .o_data(o_data0), .o_last(o_last0),
      .o_sel(o_sel0), .i_ready(i_ready)
   );

   stream_mux_rr #(.N(N), .W(W), .LOCK(1'b1)) dut1 (
      .clk(clk), .arst_n(arst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
      .o_ready(o_ready1), .o_valid(o_valid1), .o_data(o_data1), .o_last(o_last1),
      .o_sel(o_sel1), .i_ready(i_ready)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  last;
      logic        rdy;
      logic [3:0]  ordy;
      logic        ov;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        olast;
   } vec_t;

   vec_t va[20];
   vec_t vb[9];

   function automatic vec_t mkv(input logic [3:0] vld, input logic [3:0] last, input logic rdy,
                                input logic [3:0] ordy, input logic ov, input logic [3:0] sel,
                                input logic [31:0] dat, input logic olast);
      vec_t v;
      v.vld = vld; v.last = last; v.rdy = rdy; v.ordy = ordy;
      v.ov = ov; v.sel = sel; v.dat = dat; v.olast = olast;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input bit d, input string tag, input logic ov, input logic [3:0] sel,
                          input logic [31:0] dat, input logic olast);
      chk({tag, ".o_valid"}, 32'(d ? o_valid1 : o_valid0), 32'(ov));
      chk({tag, ".o_sel"},   32'(d ? o_sel1 : o_sel0),     32'(sel));
      chk({tag, ".o_data"},  d ? o_data1 : o_data0,         dat);
      chk({tag, ".o_last"},  32'(d ? o_last1 : o_last0),   32'(olast));
   endtask

   // Entered and left at posedge+1; o_ready is sampled at the negedge in between.
   task automatic step(input vec_t v, input bit d, input string tag);
      i_valid = v.vld;
      i_last  = v.last;
      i_ready = v.rdy;
      @(negedge clk);
      chk({tag, ".o_ready"}, 32'(d ? o_ready1 : o_ready0), 32'(v.ordy));
      @(posedge clk);
      #1;
      chk_out(d, tag, v.ov, v.sel, v.dat, v.olast);
   endtask

   initial begin
      // LOCK=0: round robin, sparse requests, backpressure, retention
      va[0]  = mkv(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h100, 1'b0);
      va[1]  = mkv(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      va[2]  = mkv(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100, 32'h102, 1'b0);
      va[3]  = mkv(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000, 32'h103, 1'b0);
      va[4]  = mkv(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h100, 1'b0);
      va[5]  = mkv(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      va[6]  = mkv(4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000, 32'h103, 1'b0);
      va[7]  = mkv(4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      va[8]  = mkv(4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000, 32'h103, 1'b0);
      for (int i = 9; i < 14; i++)
         va[i] = mkv(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 32'h103, 1'b0);
      va[14] = mkv(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h100, 1'b0);
      va[15] = mkv(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001, 32'h100, 1'b0);
      va[16] = mkv(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 32'h100, 1'b0);
      va[17] = mkv(4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 4'b0100, 32'h102, 1'b1);
      va[18] = mkv(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0100, 32'h102, 1'b1);
      va[19] = mkv(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h100, 1'b0);

      // LOCK=1: 3-beat packet on channel 1 with an idle gap, then re-lock before reset
      vb[0] = mkv(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h100, 1'b1);
      vb[1] = mkv(4'b0111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      vb[2] = mkv(4'b0101, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 32'h101, 1'b0);
      vb[3] = mkv(4'b0111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      vb[4] = mkv(4'b0111, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b1);
      vb[5] = mkv(4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 32'h102, 1'b1);
      vb[6] = mkv(4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      vb[7] = mkv(4'b0111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h101, 1'b0);
      vb[8] = mkv(4'b0111, 4'b0111, 1'b1, 4'b0001, 1'b1, 4'b0001, 32'h100, 1'b1);

      arst_n  = 1'b0;
      i_valid = '1;
      i_last  = '0;
      i_ready = 1'b1;
      for (int k = 0; k < N; k++) i_data[k] = 32'h100 | 32'(k);

      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk_out(d[0], $sformatf("rst%0d", d), 1'b0, 4'b0000, 32'h0, 1'b0);
         chk($sformatf("rst%0d.o_ready", d), 32'(d[0] ? o_ready1 : o_ready0), 32'h0);
      end
      arst_n = 1'b1;

      for (int i = 0; i < 20; i++) step(va[i], 1'b0, $sformatf("A%0d", i));

      arst_n = 1'b0;
      #1;
      @(posedge clk);
      #1;
      arst_n = 1'b1;

      for (int i = 0; i < 8; i++) step(vb[i], 1'b1, $sformatf("B%0d", i));

      // Reset in the middle of a locked packet on channel 1
      arst_n = 1'b0;
      #1;
      chk_out(1'b1, "midrst", 1'b0, 4'b0000, 32'h0, 1'b0);
      @(negedge clk);
      i_valid = 4'b0111;
      i_last  = 4'b0111;
      i_ready = 1'b1;
      chk("midrst.o_ready", 32'(o_ready1), 32'h0);
      @(posedge clk);
      #1;
      chk("midrst_hold.o_valid", 32'(o_valid1), 32'h0);
      arst_n = 1'b1;
      step(vb[8], 1'b1, "B8");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
